// File: rtl/mmio_timer_bank.sv
// Memory-mapped bank of N_CH prescaled timers with reload, one-shot mode and
// sticky write-1-to-clear interrupt status driving one level interrupt.
module mmio_timer_bank #(
    parameter int          N_CH      = 2,
    parameter int          CNT_W     = 32,
    parameter int          PRESC_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irqout,
    output logic [N_CH-1:0] tick_out
);

    localparam logic [31:0] STATUS_OFF = 32'(16 * N_CH);

    logic [31:0]     off_s;
    logic            status_sel_s;
    logic [N_CH-1:0] pending_r;
    logic [N_CH-1:0] tick_r;
    logic [N_CH-1:0] ovf_s;
    logic [N_CH-1:0] ie_s;
    logic [31:0]     ch_rd_s [N_CH];
    logic [31:0]     rdata_s;
    logic            unused_wdata_s;

    // Offset wraps for addresses below the base, so a single equality is a full compare.
    assign off_s          = addr - BASE_ADDR;
    assign status_sel_s   = (off_s == STATUS_OFF);
    assign unused_wdata_s = ^wdata;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        localparam logic [31:0] CH_OFF = 32'(16 * g);

        logic [CNT_W-1:0]   th_r;
        logic [CNT_W-1:0]   tl_r;
        logic               en_r;
        logic               ie_r;
        logic               mode_r;
        logic [PRESC_W-1:0] presc_r;
        logic [PRESC_W-1:0] pc_r;
        logic               sel_th_s;
        logic               sel_tl_s;
        logic               sel_ctrl_s;
        logic               strobe_s;
        logic               tl_max_s;
        logic [31:0]        rd_val_s;

        assign sel_th_s   = (off_s == CH_OFF);
        assign sel_tl_s   = (off_s == CH_OFF + 32'd4);
        assign sel_ctrl_s = (off_s == CH_OFF + 32'd8);
        assign strobe_s   = en_r && (pc_r == presc_r);
        assign tl_max_s   = (tl_r == {CNT_W{1'b1}});
        // A bus write to TL in the strobe cycle suppresses the overflow entirely.
        assign ovf_s[g]   = strobe_s && tl_max_s && !(wr && sel_tl_s);
        assign ie_s[g]    = ie_r;
        assign ch_rd_s[g] = rd_val_s;

        // Channel registers: bus writes take priority over counting; reload reads the old TH.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                th_r    <= '0;
                tl_r    <= '0;
                en_r    <= 1'b0;
                ie_r    <= 1'b0;
                mode_r  <= 1'b0;
                presc_r <= '0;
                pc_r    <= '0;
            end else begin
                if (wr && sel_th_s) begin
                    th_r <= wdata[CNT_W-1:0];
                end else begin
                    th_r <= th_r;
                end

                if (wr && sel_tl_s) begin
                    tl_r <= wdata[CNT_W-1:0];
                end else if (strobe_s) begin
                    tl_r <= tl_max_s ? th_r : tl_r + CNT_W'(1);
                end else begin
                    tl_r <= tl_r;
                end

                if (wr && sel_ctrl_s) begin
                    en_r    <= wdata[0];
                    ie_r    <= wdata[1];
                    mode_r  <= wdata[2];
                    presc_r <= wdata[8 +: PRESC_W];
                end else if (ovf_s[g] && mode_r) begin
                    en_r    <= 1'b0;
                end else begin
                    en_r    <= en_r;
                end

                if (wr && sel_ctrl_s) begin
                    pc_r <= '0;
                end else if (en_r) begin
                    pc_r <= strobe_s ? '0 : pc_r + PRESC_W'(1);
                end else begin
                    pc_r <= pc_r;
                end
            end
        end

        // Per-channel read mux, zero when none of this channel's registers is addressed.
        always_comb begin
            rd_val_s = 32'd0;
            if (sel_th_s) begin
                rd_val_s = 32'(th_r);
            end else if (sel_tl_s) begin
                rd_val_s = 32'(tl_r);
            end else if (sel_ctrl_s) begin
                rd_val_s = 32'({presc_r, 5'd0, mode_r, ie_r, en_r});
            end else begin
                rd_val_s = 32'd0;
            end
        end
    end

    // Sticky pending: overflow set wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= '0;
            tick_r    <= '0;
        end else begin
            if (wr && status_sel_s) begin
                pending_r <= (pending_r & ~wdata[N_CH-1:0]) | ovf_s;
            end else begin
                pending_r <= pending_r | ovf_s;
            end
            tick_r <= ovf_s;
        end
    end

    // Bus read data: OR of channel muxes, or STATUS; zero when not reading.
    always_comb begin
        rdata_s = 32'd0;
        if (rd) begin
            if (status_sel_s) begin
                rdata_s = 32'(pending_r);
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    rdata_s = rdata_s | ch_rd_s[c];
                end
            end
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign rdata    = rdata_s;
    assign irqout   = |(pending_r & ie_s);
    assign tick_out = tick_r;

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed self-checking bench for mmio_timer_bank (2 channels, 32-bit counters).
`timescale 1ns/1ps
module tb_mmio_timer_bank;

    localparam logic [31:0] B  = 32'h4000_0000;
    localparam logic [31:0] ST = 32'h4000_0020;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irqout;
    logic [1:0]  tick_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] v;

    mmio_timer_bank #(
        .N_CH(2), .CNT_W(32), .PRESC_W(8), .BASE_ADDR(32'h4000_0000)
    ) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .irqout(irqout), .tick_out(tick_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; the write lands on the next rising edge.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d    = rdata;
        rd   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus_rd(a, r);
        check_eq(tag, r, exp);
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: reset state
        chk_reg("rst_th0", B, 32'd0);
        chk_reg("rst_tl0", B + 32'd4, 32'd0);
        chk_reg("rst_ctrl0", B + 32'd8, 32'd0);
        chk_reg("rst_status", ST, 32'd0);
        check_eq("rst_irq", {31'd0, irqout}, 32'd0);
        check_eq("rst_tick", {30'd0, tick_out}, 32'd0);
        addr = B; rd = 1'b0; #1;
        check_eq("rd0_rdata", rdata, 32'd0);

        // 2: ch0 auto-reload, presc 0
        bus_wr(B, 32'hFFFF_FFFC);
        bus_wr(B + 32'd4, 32'hFFFF_FFFC);
        bus_wr(B + 32'd8, 32'h0000_0003);
        repeat (3) @(negedge clk);
        chk_reg("ar_tl_max", B + 32'd4, 32'hFFFF_FFFF);
        check_eq("ar_tick_pre", {30'd0, tick_out}, 32'd0);
        @(negedge clk);
        chk_reg("ar_tl_reload", B + 32'd4, 32'hFFFF_FFFC);
        check_eq("ar_tick", {30'd0, tick_out}, 32'd1);
        chk_reg("ar_status", ST, 32'd1);
        check_eq("ar_irq", {31'd0, irqout}, 32'd1);
        @(negedge clk);
        check_eq("ar_tick_1cyc", {30'd0, tick_out}, 32'd0);
        addr = B; rd = 1'b0; #1;
        check_eq("rd0_rdata2", rdata, 32'd0);
        bus_wr(ST, 32'd1);
        check_eq("w1c_irq", {31'd0, irqout}, 32'd0);
        chk_reg("w1c_status", ST, 32'd0);
        chk_reg("w1c_tl", B + 32'd4, 32'hFFFF_FFFE);
        repeat (2) @(negedge clk);
        check_eq("ar_tick2", {30'd0, tick_out}, 32'd1);
        chk_reg("ar_tl2", B + 32'd4, 32'hFFFF_FFFC);
        bus_wr(B + 32'd8, 32'd0);
        bus_wr(ST, 32'h0000_00FF);

        // 3: ch1 one-shot, presc 2
        bus_wr(B + 32'h14, 32'hFFFF_FFFE);
        bus_wr(B + 32'h10, 32'd0);
        bus_wr(B + 32'h18, 32'h0000_0205);
        repeat (5) @(negedge clk);
        chk_reg("os_tl_max", B + 32'h14, 32'hFFFF_FFFF);
        chk_reg("os_status_pre", ST, 32'd0);
        @(negedge clk);
        chk_reg("os_tl", B + 32'h14, 32'd0);
        chk_reg("os_ctrl", B + 32'h18, 32'h0000_0204);
        chk_reg("os_status", ST, 32'd2);
        check_eq("os_tick", {30'd0, tick_out}, 32'd2);
        check_eq("os_irq", {31'd0, irqout}, 32'd0);
        repeat (8) @(negedge clk);
        chk_reg("os_tl_hold", B + 32'h14, 32'd0);
        bus_wr(ST, 32'd2);

        // 4: TL write beats overflow
        bus_wr(B + 32'd4, 32'hFFFF_FFFF);
        bus_wr(B + 32'd8, 32'd1);
        bus_wr(B + 32'd4, 32'd5);
        chk_reg("tlw_tl", B + 32'd4, 32'd5);
        chk_reg("tlw_status", ST, 32'd0);
        check_eq("tlw_tick", {30'd0, tick_out}, 32'd0);
        @(negedge clk);
        chk_reg("tlw_tl_next", B + 32'd4, 32'd6);
        check_eq("tlw_tick_next", {30'd0, tick_out}, 32'd0);
        bus_wr(B + 32'd8, 32'd0);

        // 5: overflow beats W1C; ie masks but keeps pending
        bus_wr(B + 32'd4, 32'hFFFF_FFFE);
        bus_wr(B + 32'd8, 32'd1);
        @(negedge clk);
        bus_wr(ST, 32'd1);
        chk_reg("col_status", ST, 32'd1);
        check_eq("col_irq_masked", {31'd0, irqout}, 32'd0);
        chk_reg("col_tl", B + 32'd4, 32'hFFFF_FFFC);
        bus_wr(B + 32'd8, 32'd2);
        check_eq("ie_irq", {31'd0, irqout}, 32'd1);
        chk_reg("ie_tl_oldctrl", B + 32'd4, 32'hFFFF_FFFD);
        bus_wr(B + 32'd8, 32'd0);
        check_eq("ie_off_irq", {31'd0, irqout}, 32'd0);
        chk_reg("ie_off_status", ST, 32'd1);
        bus_wr(ST, 32'd1);

        // TH write during overflow: reload uses the old TH
        bus_wr(B + 32'd4, 32'hFFFF_FFFF);
        bus_wr(B + 32'd8, 32'd1);
        bus_wr(B, 32'h0000_0100);
        chk_reg("thc_tl", B + 32'd4, 32'hFFFF_FFFC);
        chk_reg("thc_th", B, 32'h0000_0100);
        bus_wr(B + 32'd8, 32'd0);
        bus_wr(ST, 32'd1);

        // 6: reserved/unmapped, ignored writes, async reset
        chk_reg("rsv_c", B + 32'h0C, 32'd0);
        chk_reg("rsv_st4", ST + 32'd4, 32'd0);
        bus_wr(B + 32'h1000_0000, 32'h55);
        chk_reg("unmap_th", B, 32'h0000_0100);
        chk_reg("unmap_rd", B + 32'h1000_0000, 32'd0);
        addr = B; wdata = 32'hABC; wr = 1'b0;
        @(negedge clk);
        chk_reg("wr0_th", B, 32'h0000_0100);
        bus_wr(B + 32'd4, 32'hFFFF_FFFE);
        bus_wr(B + 32'd8, 32'd3);
        repeat (2) @(negedge clk);
        check_eq("pre_rst_irq", {31'd0, irqout}, 32'd1);
        chk_reg("pre_rst_tl", B + 32'd4, 32'h0000_0100);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_reg("arst_tl", B + 32'd4, 32'd0);
        chk_reg("arst_ctrl", B + 32'd8, 32'd0);
        chk_reg("arst_th", B, 32'd0);
        chk_reg("arst_status", ST, 32'd0);
        check_eq("arst_irq", {31'd0, irqout}, 32'd0);
        check_eq("arst_tick", {30'd0, tick_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reg("post_rst_tl", B + 32'd4, 32'd0);
        check_eq("post_rst_tick", {30'd0, tick_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
